// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command sequencer.
//  - state_e      : command FSM state encoding
//  - HDR_OPC      : opcode header length in bytes
//  - HDR_ADDR     : address header length in bytes
//  - DUMMY_BYTE   : default MOSI byte during read data phase
//  - addr_byte()  : selects address byte 0..2, MSB byte first
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPCODE,
    ST_ADDR,
    ST_DATA,
    ST_WAIT_RX,
    ST_DONE
  } state_e;

  localparam int          HDR_OPC    = 1;
  localparam int          HDR_ADDR   = 3;
  localparam logic [7:0]  DUMMY_BYTE = 8'h00;

  function automatic logic [7:0] addr_byte(input logic [23:0] addr, input logic [1:0] idx);
    case (idx)
      2'd0:    return addr[23:16];
      2'd1:    return addr[15:8];
      default: return addr[7:0];
    endcase
  endfunction

endpackage

// File: rtl/spi_cmd_ctrl.sv
// SPI command sequencer: issues opcode, optional 24-bit address and N data
// bytes to a byte-level SPI engine over a valid/ready handshake, counts the
// returned rx bytes and forwards only data-phase read bytes to the user.
//
// Ports
//  i_clk, i_rst                       clock, synchronous active-high reset
//  i_cmd_valid / o_cmd_ready          command handshake (ready only in IDLE)
//  i_cmd_opcode, i_cmd_addr_en,
//  i_cmd_addr, i_cmd_rw, i_cmd_len    command fields, captured on accept
//  i_wr_data/i_wr_valid/o_wr_ready    write payload stream (pass-through)
//  o_rd_data/o_rd_valid               read payload bytes, 1-cycle strobes
//  o_busy, o_done                     busy from accept until done pulse
//  o_drv_data/o_drv_valid/i_drv_ready byte stream to the SPI engine
//  i_drv_rd_data/i_drv_rd_valid       rx bytes from the SPI engine
module spi_cmd_ctrl
  import spi_pkg::*;
#(
  parameter int         P_LEN_WIDTH  = 16,
  parameter logic [7:0] P_DUMMY_BYTE = DUMMY_BYTE
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic [7:0]             i_cmd_opcode,
  input  logic                   i_cmd_addr_en,
  input  logic [23:0]            i_cmd_addr,
  input  logic                   i_cmd_rw,
  input  logic [P_LEN_WIDTH-1:0] i_cmd_len,
  input  logic [7:0]             i_wr_data,
  input  logic                   i_wr_valid,
  output logic                   o_wr_ready,
  output logic [7:0]             o_rd_data,
  output logic                   o_rd_valid,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [7:0]             o_drv_data,
  output logic                   o_drv_valid,
  input  logic                   i_drv_ready,
  input  logic [7:0]             i_drv_rd_data,
  input  logic                   i_drv_rd_valid
);

  // rx counter carries one extra bit so H + max N never wraps
  localparam int                   CW      = P_LEN_WIDTH + 1;
  localparam logic [P_LEN_WIDTH-1:0] LEN_ONE = 1;
  localparam logic [CW-1:0]          CNT_ONE = 1;

  state_e                 state_q;
  logic [23:0]            addr_q;
  logic                   addr_en_q;
  logic                   rw_q;
  logic [P_LEN_WIDTH-1:0] len_q;
  logic [P_LEN_WIDTH-1:0] tx_cnt_q;
  logic [1:0]             addr_idx_q;
  logic [CW-1:0]          rx_cnt_q;
  logic [CW-1:0]          total_q;
  logic                   cmd_ready_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   rd_valid_q;
  logic [7:0]             rd_data_q;
  logic                   drv_valid_q;
  logic [7:0]             drv_data_q;

  logic          wr_phase;
  logic          drv_hs;
  logic          rx_active;
  logic [CW-1:0] hdr_len;
  state_e        post_hdr_st;
  logic          post_hdr_vld;

  // Write data phase bypasses the output registers so payload bytes reach
  // the engine with zero latency and user stalls stall the bus directly.
  assign wr_phase    = (state_q == ST_DATA) && !rw_q;
  assign o_drv_valid = wr_phase ? i_wr_valid : drv_valid_q;
  assign o_drv_data  = wr_phase ? i_wr_data  : drv_data_q;
  assign o_wr_ready  = wr_phase && i_drv_ready;
  assign drv_hs      = o_drv_valid && i_drv_ready;

  assign rx_active = (state_q == ST_OPCODE) || (state_q == ST_ADDR) ||
                     (state_q == ST_DATA)   || (state_q == ST_WAIT_RX);
  assign hdr_len   = addr_en_q ? CW'(HDR_OPC + HDR_ADDR) : CW'(HDR_OPC);

  // Where to go once the header is out; only a read data phase drives the
  // registered valid (with the dummy byte).
  assign post_hdr_st  = (len_q != '0) ? ST_DATA : ST_WAIT_RX;
  assign post_hdr_vld = (len_q != '0) && rw_q;

  assign o_cmd_ready = cmd_ready_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_rd_valid  = rd_valid_q;
  assign o_rd_data   = rd_data_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      addr_en_q   <= 1'b0;
      rw_q        <= 1'b0;
      len_q       <= '0;
      tx_cnt_q    <= '0;
      addr_idx_q  <= '0;
      rx_cnt_q    <= '0;
      total_q     <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      drv_valid_q <= 1'b0;
      drv_data_q  <= '0;
    end else begin
      rd_valid_q <= 1'b0;

      // rx bytes are counted in every active phase; only those beyond the
      // header of a read command go to the user
      if (rx_active && i_drv_rd_valid) begin
        rx_cnt_q <= rx_cnt_q + CNT_ONE;
        if (rw_q && (rx_cnt_q >= hdr_len)) begin
          rd_valid_q <= 1'b1;
          rd_data_q  <= i_drv_rd_data;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (i_cmd_valid && cmd_ready_q) begin
            addr_q      <= i_cmd_addr;
            addr_en_q   <= i_cmd_addr_en;
            rw_q        <= i_cmd_rw;
            len_q       <= i_cmd_len;
            tx_cnt_q    <= '0;
            addr_idx_q  <= '0;
            rx_cnt_q    <= '0;
            total_q     <= CW'(HDR_OPC) + (i_cmd_addr_en ? CW'(HDR_ADDR) : '0) + CW'(i_cmd_len);
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            drv_valid_q <= 1'b1;
            drv_data_q  <= i_cmd_opcode;
            state_q     <= ST_OPCODE;
          end
        end

        ST_OPCODE: begin
          if (drv_hs) begin
            if (addr_en_q) begin
              addr_idx_q <= '0;
              drv_data_q <= addr_byte(addr_q, 2'd0);
              state_q    <= ST_ADDR;
            end else begin
              drv_valid_q <= post_hdr_vld;
              drv_data_q  <= P_DUMMY_BYTE;
              state_q     <= post_hdr_st;
            end
          end
        end

        ST_ADDR: begin
          if (drv_hs) begin
            if (addr_idx_q == 2'd2) begin
              drv_valid_q <= post_hdr_vld;
              drv_data_q  <= P_DUMMY_BYTE;
              state_q     <= post_hdr_st;
            end else begin
              addr_idx_q <= addr_idx_q + 2'd1;
              drv_data_q <= addr_byte(addr_q, addr_idx_q + 2'd1);
            end
          end
        end

        ST_DATA: begin
          if (drv_hs) begin
            tx_cnt_q <= tx_cnt_q + LEN_ONE;
            if (tx_cnt_q == (len_q - LEN_ONE)) begin
              drv_valid_q <= 1'b0;
              state_q     <= ST_WAIT_RX;
            end
          end
        end

        ST_WAIT_RX: begin
          if (rx_cnt_q == total_q) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end

        ST_DONE: begin
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Bench for spi_cmd_ctrl. A behavioural byte engine stands in for the SPI
// driver: it accepts one byte, stays busy a few cycles, then returns the same
// byte as its rx byte (MISO looped to MOSI).
module tb_spi_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [7:0]  i_cmd_opcode;
  logic        i_cmd_addr_en;
  logic [23:0] i_cmd_addr;
  logic        i_cmd_rw;
  logic [15:0] i_cmd_len;
  logic [7:0]  i_wr_data;
  logic        i_wr_valid;
  logic        o_wr_ready;
  logic [7:0]  o_rd_data;
  logic        o_rd_valid;
  logic        o_busy;
  logic        o_done;
  logic [7:0]  o_drv_data;
  logic        o_drv_valid;
  logic        drv_ready;
  logic [7:0]  drv_rd_data;
  logic        drv_rd_valid;

  always #5 clk = ~clk;

  spi_cmd_ctrl #(.P_LEN_WIDTH(16), .P_DUMMY_BYTE(8'h00)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_cmd_valid    (i_cmd_valid),
    .o_cmd_ready    (o_cmd_ready),
    .i_cmd_opcode   (i_cmd_opcode),
    .i_cmd_addr_en  (i_cmd_addr_en),
    .i_cmd_addr     (i_cmd_addr),
    .i_cmd_rw       (i_cmd_rw),
    .i_cmd_len      (i_cmd_len),
    .i_wr_data      (i_wr_data),
    .i_wr_valid     (i_wr_valid),
    .o_wr_ready     (o_wr_ready),
    .o_rd_data      (o_rd_data),
    .o_rd_valid     (o_rd_valid),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_drv_data     (o_drv_data),
    .o_drv_valid    (o_drv_valid),
    .i_drv_ready    (drv_ready),
    .i_drv_rd_data  (drv_rd_data),
    .i_drv_rd_valid (drv_rd_valid)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // byte engine model
  logic [7:0] mosi_q[$];
  int         m_cnt;
  logic [7:0] m_byte;

  always @(posedge clk) begin
    if (rst) begin
      drv_ready    <= 1'b1;
      drv_rd_valid <= 1'b0;
      drv_rd_data  <= 8'h00;
      m_cnt        <= 0;
      m_byte       <= 8'h00;
    end else begin
      drv_rd_valid <= 1'b0;
      if (drv_ready && o_drv_valid) begin
        mosi_q.push_back(o_drv_data);
        m_byte    <= o_drv_data;
        drv_ready <= 1'b0;
        m_cnt     <= 3;
      end else if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          drv_rd_valid <= 1'b1;
          drv_rd_data  <= m_byte;
          drv_ready    <= 1'b1;
        end
      end
    end
  end

  // write payload source: bytes queued by the stimulus, optionally gapped
  logic [7:0] wr_src[$];
  int         wr_idx = 0;
  int         ph     = 0;
  logic       gap    = 1'b0;

  always @(negedge clk) begin
    ph = (ph == 2) ? 0 : ph + 1;
    if ((wr_idx < wr_src.size()) && (!gap || ph == 0)) begin
      i_wr_valid = 1'b1;
      i_wr_data  = wr_src[wr_idx];
    end else begin
      i_wr_valid = 1'b0;
      i_wr_data  = 8'h00;
    end
  end

  // monitors
  logic [7:0] rd_q[$];
  int         wr_hs    = 0;
  int         done_cnt = 0;
  int         stab_err = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = 8'h00;

  always @(posedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (o_wr_ready && i_wr_valid) begin
        wr_hs++;
        wr_idx++;
      end
      if (o_rd_valid) rd_q.push_back(o_rd_data);
      if (o_done) done_cnt++;
      if (stall_prev && o_drv_valid && (o_drv_data != stall_data)) stab_err++;
      stall_prev = o_drv_valid && !drv_ready;
      stall_data = o_drv_data;
    end
  end

  logic [7:0] exp_q[$];

  task automatic check_mosi(input string tag, input int base);
    chk({tag, "_nbytes"}, mosi_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < mosi_q.size())
        chk($sformatf("%s_b%0d", tag, i), mosi_q[base + i], exp_q[i]);
    end
  endtask

  task automatic send_cmd(input logic [7:0] opc, input logic aen, input logic [23:0] adr,
                          input logic rw, input logic [15:0] len);
    int t;
    t = 0;
    @(negedge clk);
    i_cmd_opcode  = opc;
    i_cmd_addr_en = aen;
    i_cmd_addr    = adr;
    i_cmd_rw      = rw;
    i_cmd_len     = len;
    i_cmd_valid   = 1'b1;
    while (!o_cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!o_cmd_ready) chk("cmd_accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (done_cnt < target && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt < target) chk("done_timeout", done_cnt, target);
    repeat (6) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, o_cmd_ready, 1);
    chk({tag, "_busy"},      o_busy,      0);
    chk({tag, "_done"},      o_done,      0);
    chk({tag, "_rd_valid"},  o_rd_valid,  0);
    chk({tag, "_drv_valid"}, o_drv_valid, 0);
    chk({tag, "_wr_ready"},  o_wr_ready,  0);
    chk({tag, "_rd_data"},   o_rd_data,   0);
    chk({tag, "_drv_data"},  o_drv_data,  0);
  endtask

  int mb, rb, wb, db;
  int cyc, acc, dn, bad, t;

  initial begin
    rst           = 1'b1;
    i_cmd_valid   = 1'b0;
    i_cmd_opcode  = 8'h00;
    i_cmd_addr_en = 1'b0;
    i_cmd_addr    = 24'h0;
    i_cmd_rw      = 1'b0;
    i_cmd_len     = 16'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("rst");

    // opcode-only command
    mb = mosi_q.size(); rb = rd_q.size(); db = done_cnt;
    send_cmd(8'h06, 1'b0, 24'h0, 1'b0, 16'd0);
    wait_done(db + 1);
    exp_q = '{8'h06};
    check_mosi("opc_only", mb);
    chk("opc_only_rd", rd_q.size() - rb, 0);
    chk("opc_only_done", done_cnt - db, 1);

    // write with address
    mb = mosi_q.size(); rb = rd_q.size(); db = done_cnt; wb = wr_hs;
    gap = 1'b0;
    wr_src.push_back(8'hA5); wr_src.push_back(8'h5A); wr_src.push_back(8'hC3);
    send_cmd(8'h02, 1'b1, 24'h123456, 1'b0, 16'd3);
    wait_done(db + 1);
    exp_q = '{8'h02, 8'h12, 8'h34, 8'h56, 8'hA5, 8'h5A, 8'hC3};
    check_mosi("wr3", mb);
    chk("wr3_wr_hs", wr_hs - wb, 3);
    chk("wr3_rd", rd_q.size() - rb, 0);
    chk("wr3_done", done_cnt - db, 1);

    // read with address
    mb = mosi_q.size(); rb = rd_q.size(); db = done_cnt; wb = wr_hs;
    send_cmd(8'h03, 1'b1, 24'h000010, 1'b1, 16'd2);
    wait_done(db + 1);
    exp_q = '{8'h03, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00};
    check_mosi("rd2", mb);
    chk("rd2_rd_cnt", rd_q.size() - rb, 2);
    if (rd_q.size() - rb == 2) begin
      chk("rd2_d0", rd_q[rb], 8'h00);
      chk("rd2_d1", rd_q[rb + 1], 8'h00);
    end
    chk("rd2_wr_hs", wr_hs - wb, 0);
    chk("rd2_done", done_cnt - db, 1);

    // gapped write payload, no address
    mb = mosi_q.size(); db = done_cnt; wb = wr_hs;
    gap = 1'b1;
    wr_src.push_back(8'h11); wr_src.push_back(8'h22); wr_src.push_back(8'h33); wr_src.push_back(8'h44);
    send_cmd(8'h02, 1'b0, 24'h0, 1'b0, 16'd4);
    wait_done(db + 1);
    gap = 1'b0;
    exp_q = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
    check_mosi("wrgap", mb);
    chk("wrgap_wr_hs", wr_hs - wb, 4);
    chk("wrgap_done", done_cnt - db, 1);

    // second command held valid while the first is busy
    mb = mosi_q.size(); rb = rd_q.size(); db = done_cnt;
    send_cmd(8'h20, 1'b1, 24'hABCDEF, 1'b0, 16'd0);
    i_cmd_opcode  = 8'h9F;
    i_cmd_addr_en = 1'b0;
    i_cmd_addr    = 24'h0;
    i_cmd_rw      = 1'b1;
    i_cmd_len     = 16'd1;
    i_cmd_valid   = 1'b1;
    cyc = 0; acc = -1; dn = -1; bad = 0;
    while (acc < 0 && cyc < 500) begin
      if (o_done) dn = cyc;
      if (o_busy && o_cmd_ready) bad++;
      if (o_cmd_ready) acc = cyc;
      @(negedge clk);
      cyc++;
    end
    i_cmd_valid = 1'b0;
    chk("b2b_ready_while_busy", bad, 0);
    chk("b2b_accept_after_done", acc, dn + 1);
    wait_done(db + 2);
    exp_q = '{8'h20, 8'hAB, 8'hCD, 8'hEF, 8'h9F, 8'h00};
    check_mosi("b2b", mb);
    chk("b2b_rd_cnt", rd_q.size() - rb, 1);
    chk("b2b_done", done_cnt - db, 2);

    // reset after the second address byte
    mb = mosi_q.size(); rb = rd_q.size(); db = done_cnt;
    send_cmd(8'h0B, 1'b1, 24'h778899, 1'b1, 16'd2);
    t = 0;
    while (mosi_q.size() - mb < 3 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("abort_reach_addr2", mosi_q.size() - mb, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("abort");
    repeat (20) @(negedge clk);
    exp_q = '{8'h0B, 8'h77, 8'h88};
    check_mosi("abort", mb);
    chk("abort_rd", rd_q.size() - rb, 0);
    chk("abort_done", done_cnt - db, 0);

    // fresh command after the abort
    mb = mosi_q.size(); rb = rd_q.size(); db = done_cnt;
    send_cmd(8'h06, 1'b0, 24'h0, 1'b0, 16'd0);
    wait_done(db + 1);
    exp_q = '{8'h06};
    check_mosi("post_abort", mb);
    chk("post_abort_rd", rd_q.size() - rb, 0);
    chk("post_abort_done", done_cnt - db, 1);

    chk("drv_data_stable", stab_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
